// File: rtl/trivium_prng_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trivium_prng_pkg
// Purpose  : Shared constants, tap positions, FSM encoding and the reseed
//            load helper for the unrolled Trivium PRNG.
// Revision : 1.0 - initial release
// ============================================================================
package trivium_prng_pkg;

  // Register geometry. Bit k-1 of the state vector holds Trivium cell s_k.
  localparam int STATE_W  = 288;
  localparam int REG1_LEN = 93;
  localparam int REG2_LEN = 84;
  localparam int REG3_LEN = 111;
  localparam int REG1_LO  = 0;
  localparam int REG2_LO  = REG1_LO + REG1_LEN;  // s94
  localparam int REG3_LO  = REG2_LO + REG2_LEN;  // s178

  localparam int KEY_W = 80;
  localparam int IV_W  = 80;

  // Linear output taps (zero-based: s66 -> 65, etc.).
  localparam int TAP_T1_A = 65;   // s66
  localparam int TAP_T1_B = 92;   // s93
  localparam int TAP_T2_A = 161;  // s162
  localparam int TAP_T2_B = 176;  // s177
  localparam int TAP_T3_A = 242;  // s243
  localparam int TAP_T3_B = 287;  // s288

  // Nonlinear feedback taps.
  localparam int TAP_A1_X = 90;   // s91
  localparam int TAP_A1_Y = 91;   // s92
  localparam int TAP_F1   = 170;  // s171
  localparam int TAP_A2_X = 174;  // s175
  localparam int TAP_A2_Y = 175;  // s176
  localparam int TAP_F2   = 263;  // s264
  localparam int TAP_A3_X = 285;  // s286
  localparam int TAP_A3_Y = 286;  // s287
  localparam int TAP_F3   = 68;   // s69

  localparam int WARMUP_STEPS = 1152;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } prng_state_e;

  // Initial state image for a reseed: key in s1..s80, IV in s94..s173,
  // s286..s288 set, everything else cleared.
  function automatic logic [STATE_W-1:0] load_state(input logic [KEY_W-1:0] key,
                                                    input logic [IV_W-1:0]  iv);
    logic [STATE_W-1:0] st;
    st                              = '0;
    st[REG1_LO +: KEY_W]            = key;
    st[REG2_LO +: IV_W]             = iv;
    st[STATE_W-1 -: 3]              = 3'b111;
    return st;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trivium_prng_if.sv
`default_nettype none
// ============================================================================
// Module   : trivium_prng_if
// Purpose  : Seed / reseed request and keystream valid/ready handshake
//            between the masked AES wrapper and the Trivium PRNG.
// Revision : 1.0 - initial release
// ============================================================================
interface trivium_prng_if #(
  parameter int UNROLL = 64
);
  logic [79:0]       prng_seed;
  logic              prng_start_reseed;
  logic              prng_out_ready;
  logic              prng_out_valid;
  logic [UNROLL-1:0] prng_out_rnd;
  logic              prng_busy;

  modport master (
    output prng_seed, prng_start_reseed, prng_out_ready,
    input  prng_out_valid, prng_out_rnd, prng_busy
  );

  modport slave (
    input  prng_seed, prng_start_reseed, prng_out_ready,
    output prng_out_valid, prng_out_rnd, prng_busy
  );
endinterface
`default_nettype wire

// File: rtl/trivium_step.sv
`default_nettype none
// ============================================================================
// Module   : trivium_step
// Purpose  : One combinational Trivium step: produces keystream bit z from
//            the incoming state and the shifted, fed-back next state.
// Revision : 1.0 - initial release
// ============================================================================
module trivium_step
  import trivium_prng_pkg::*;
(
  input  wire logic [STATE_W-1:0] i_state,
  output logic      [STATE_W-1:0] o_state,
  output logic                    o_z
);

  logic w_t1;
  logic w_t2;
  logic w_t3;
  logic w_t1_fb;
  logic w_t2_fb;
  logic w_t3_fb;

  // Linear taps form the output bit before the nonlinear terms are folded in.
  assign w_t1 = i_state[TAP_T1_A] ^ i_state[TAP_T1_B];
  assign w_t2 = i_state[TAP_T2_A] ^ i_state[TAP_T2_B];
  assign w_t3 = i_state[TAP_T3_A] ^ i_state[TAP_T3_B];
  assign o_z  = w_t1 ^ w_t2 ^ w_t3;

  assign w_t1_fb = w_t1 ^ (i_state[TAP_A1_X] & i_state[TAP_A1_Y]) ^ i_state[TAP_F1];
  assign w_t2_fb = w_t2 ^ (i_state[TAP_A2_X] & i_state[TAP_A2_Y]) ^ i_state[TAP_F2];
  assign w_t3_fb = w_t3 ^ (i_state[TAP_A3_X] & i_state[TAP_A3_Y]) ^ i_state[TAP_F3];

  // Each register shifts up by one; its head takes the feedback of the
  // register that precedes it in the ring (t3 -> reg1, t1 -> reg2, t2 -> reg3).
  assign o_state = {i_state[STATE_W-2 : REG3_LO], w_t2_fb,
                    i_state[REG3_LO-2 : REG2_LO], w_t1_fb,
                    i_state[REG2_LO-2 : REG1_LO], w_t3_fb};

endmodule
`default_nettype wire

// File: rtl/trivium_prng.sv
`default_nettype none
// ============================================================================
// Module   : trivium_prng
// Purpose  : Unrolled Trivium keystream generator. Loads a key on reseed,
//            runs the 1152-step warm-up, then delivers UNROLL keystream bits
//            per accepted valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module trivium_prng
  import trivium_prng_pkg::*;
#(
  parameter int          UNROLL = 64,
  parameter logic [79:0] IV     = 80'h0
) (
  input  wire logic      clk,
  input  wire logic      nrst,
  trivium_prng_if.slave  bus
);

  localparam int WARMUP_CYCLES = WARMUP_STEPS / UNROLL;
  localparam int CNT_W         = $clog2(WARMUP_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WARMUP_CYCLES - 1);

  prng_state_e        r_fsm;
  logic [STATE_W-1:0] r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_valid;
  logic               r_busy;

  logic [STATE_W-1:0] w_chain [0:UNROLL];
  logic [UNROLL-1:0]  w_z;

  assign w_chain[0] = r_state;

  // Chain UNROLL single steps; stage i supplies keystream bit i.
  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
    trivium_step u_step (
      .i_state (w_chain[gi]),
      .o_state (w_chain[gi+1]),
      .o_z     (w_z[gi])
    );
  end

  assign bus.prng_out_rnd   = w_z;
  assign bus.prng_out_valid = r_valid;
  assign bus.prng_busy      = r_busy;

  // Control FSM: reseed overrides everything, warm-up advances every cycle,
  // run advances only when the current word is accepted.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_fsm   <= IDLE;
      r_state <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else if (bus.prng_start_reseed) begin
      r_fsm   <= WARMUP;
      r_state <= load_state(bus.prng_seed, IV);
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      unique case (r_fsm)
        IDLE: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
        WARMUP: begin
          r_state <= w_chain[UNROLL];
          if (r_cnt == c_cnt_last) begin
            r_fsm   <= RUN;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RUN: begin
          if (r_valid && bus.prng_out_ready) begin
            r_state <= w_chain[UNROLL];
          end
        end
        default: begin
          r_fsm   <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trivium_prng.sv
`default_nettype none
// ============================================================================
// Module   : tb_trivium_prng
// Purpose  : Self-checking bench for trivium_prng at UNROLL 1/8/32/64 against
//            a bit-serial Trivium reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trivium_prng;

  localparam int          KS_N   = 1024;
  localparam int          WARM   = 1152;
  localparam logic [79:0] TB_IV  = 80'h0;
  localparam logic [79:0] KEY_B  = 80'h0123456789ABCDEF0123;

  logic        clk;
  logic        nrst;
  logic [79:0] seed;
  logic        reseed;
  logic        rdy64;

  int n_vec;
  int n_err;

  logic [KS_N-1:0] ks_zero;
  logic [KS_N-1:0] ks_b;

  trivium_prng_if #(.UNROLL(64)) bus64 ();
  trivium_prng_if #(.UNROLL(32)) bus32 ();
  trivium_prng_if #(.UNROLL(8))  bus8  ();
  trivium_prng_if #(.UNROLL(1))  bus1  ();

  assign bus64.prng_seed = seed;  assign bus64.prng_start_reseed = reseed;  assign bus64.prng_out_ready = rdy64;
  assign bus32.prng_seed = seed;  assign bus32.prng_start_reseed = reseed;  assign bus32.prng_out_ready = 1'b1;
  assign bus8.prng_seed  = seed;  assign bus8.prng_start_reseed  = reseed;  assign bus8.prng_out_ready  = 1'b1;
  assign bus1.prng_seed  = seed;  assign bus1.prng_start_reseed  = reseed;  assign bus1.prng_out_ready  = 1'b1;

  trivium_prng #(.UNROLL(64), .IV(TB_IV)) u64 (.clk(clk), .nrst(nrst), .bus(bus64));
  trivium_prng #(.UNROLL(32), .IV(TB_IV)) u32 (.clk(clk), .nrst(nrst), .bus(bus32));
  trivium_prng #(.UNROLL(8),  .IV(TB_IV)) u8  (.clk(clk), .nrst(nrst), .bus(bus8));
  trivium_prng #(.UNROLL(1),  .IV(TB_IV)) u1  (.clk(clk), .nrst(nrst), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit-serial Trivium: cells s[1..288], 1152 discarded steps, then KS_N bits.
  function automatic logic [KS_N-1:0] trivium_ref(input logic [79:0] key, input logic [79:0] iv);
    logic s [1:288];
    logic [KS_N-1:0] ks;
    logic t1, t2, t3;
    ks = '0;
    for (int k = 1; k <= 288; k++) s[k] = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      s[k]      = key[k-1];
      s[93 + k] = iv[k-1];
    end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    for (int step = 0; step < WARM + KS_N; step++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      if (step >= WARM) ks[step - WARM] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int k = 288; k >= 2; k--) s[k] = s[k-1];
      s[1]   = t3;
      s[94]  = t1;
      s[178] = t2;
    end
    return ks;
  endfunction

  // Issue a one-cycle reseed; returns at the falling edge after the sampling edge.
  task automatic pulse_reseed(input logic [79:0] s, input logic rdy);
    seed   = s;
    reseed = 1'b1;
    rdy64  = rdy;
    @(negedge clk);
    reseed = 1'b0;
  endtask

  task automatic wait_valid64(output int cyc);
    cyc = 0;
    while (!bus64.prng_out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_vec++; if (bus64.prng_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus64.prng_out_valid); end
    n_vec++; if (bus64.prng_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus64.prng_busy); end
    n_vec++; if (bus64.prng_out_rnd !== 64'h0) begin n_err++; $display("FAIL reset_rnd got=%h exp=0", bus64.prng_out_rnd); end
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (bus64.prng_out_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got=%b exp=0", bus64.prng_out_valid); end
  endtask

  task automatic test_warmup_zero;
    int cyc;
    pulse_reseed(80'h0, 1'b1);
    n_vec++; if (bus64.prng_busy !== 1'b1) begin n_err++; $display("FAIL warm_busy got=%b exp=1", bus64.prng_busy); end
    n_vec++; if (bus64.prng_out_valid !== 1'b0) begin n_err++; $display("FAIL warm_valid got=%b exp=0", bus64.prng_out_valid); end
    wait_valid64(cyc);
    n_vec++; if (cyc != 18) begin n_err++; $display("FAIL warm_latency got=%0d exp=18", cyc); end
    n_vec++; if (bus64.prng_busy !== 1'b0) begin n_err++; $display("FAIL run_busy got=%b exp=0", bus64.prng_busy); end
    for (int j = 0; j < 8; j++) begin
      n_vec++;
      if (bus64.prng_out_rnd !== ks_zero[j*64 +: 64]) begin
        n_err++; $display("FAIL zero_word%0d got=%h exp=%h", j, bus64.prng_out_rnd, ks_zero[j*64 +: 64]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ready_toggle;
    int cyc;
    int idx;
    logic pat [0:3];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    pulse_reseed(KEY_B, 1'b1);
    wait_valid64(cyc);
    n_vec++; if (cyc != 18) begin n_err++; $display("FAIL toggle_latency got=%0d exp=18", cyc); end
    idx = 0;
    for (int k = 0; k < 12; k++) begin
      n_vec++;
      if (bus64.prng_out_valid !== 1'b1 || bus64.prng_out_rnd !== ks_b[idx*64 +: 64]) begin
        n_err++; $display("FAIL toggle_word k=%0d valid=%b got=%h exp=%h", k, bus64.prng_out_valid, bus64.prng_out_rnd, ks_b[idx*64 +: 64]);
      end
      rdy64 = pat[k % 4];
      if (rdy64) idx++;
      @(negedge clk);
    end
    rdy64 = 1'b0;
  endtask

  task automatic test_reseed_in_run;
    int cyc;
    pulse_reseed(KEY_B, 1'b0);
    n_vec++; if (bus64.prng_out_valid !== 1'b0) begin n_err++; $display("FAIL rerun_drop got=%b exp=0", bus64.prng_out_valid); end
    n_vec++; if (bus64.prng_busy !== 1'b1) begin n_err++; $display("FAIL rerun_busy got=%b exp=1", bus64.prng_busy); end
    wait_valid64(cyc);
    n_vec++; if (cyc != 18) begin n_err++; $display("FAIL rerun_latency got=%0d exp=18", cyc); end
    n_vec++; if (bus64.prng_out_rnd !== ks_b[63:0]) begin n_err++; $display("FAIL rerun_word got=%h exp=%h", bus64.prng_out_rnd, ks_b[63:0]); end
  endtask

  task automatic test_reseed_with_ready;
    int cyc;
    rdy64 = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (bus64.prng_out_rnd !== ks_b[3*64 +: 64]) begin n_err++; $display("FAIL pre_word got=%h exp=%h", bus64.prng_out_rnd, ks_b[3*64 +: 64]); end
    pulse_reseed(KEY_B, 1'b1);
    n_vec++; if (bus64.prng_out_valid !== 1'b0) begin n_err++; $display("FAIL rsr_drop got=%b exp=0", bus64.prng_out_valid); end
    wait_valid64(cyc);
    n_vec++; if (cyc != 18) begin n_err++; $display("FAIL rsr_latency got=%0d exp=18", cyc); end
    n_vec++; if (bus64.prng_out_rnd !== ks_b[63:0]) begin n_err++; $display("FAIL rsr_word got=%h exp=%h", bus64.prng_out_rnd, ks_b[63:0]); end
    @(negedge clk);
    n_vec++; if (bus64.prng_out_rnd !== ks_b[127:64]) begin n_err++; $display("FAIL rsr_word1 got=%h exp=%h", bus64.prng_out_rnd, ks_b[127:64]); end
    rdy64 = 1'b0;
  endtask

  task automatic test_reset_mid_warmup;
    logic seen_valid;
    pulse_reseed({$urandom, $urandom, 16'($urandom)}, 1'b1);
    repeat (5) @(negedge clk);
    n_vec++; if (bus64.prng_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got=%b exp=1", bus64.prng_busy); end
    #2 nrst = 1'b0;
    #1;
    n_vec++; if (bus64.prng_out_valid !== 1'b0 || bus64.prng_busy !== 1'b0) begin
      n_err++; $display("FAIL async_reset valid=%b busy=%b exp=0/0", bus64.prng_out_valid, bus64.prng_busy);
    end
    n_vec++; if (bus64.prng_out_rnd !== 64'h0) begin n_err++; $display("FAIL async_rnd got=%h exp=0", bus64.prng_out_rnd); end
    @(negedge clk);
    nrst = 1'b1;
    seen_valid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus64.prng_out_valid !== 1'b0) seen_valid = 1'b1;
    end
    n_vec++; if (seen_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_valid got=1 exp=0"); end
  endtask

  task automatic test_unroll_sweep;
    int f1, f8, f32, f64;
    int n1, n8, n32, n64;
    logic [255:0] g1, g8, g32, g64;
    f1 = -1; f8 = -1; f32 = -1; f64 = -1;
    n1 = 0;  n8 = 0;  n32 = 0;  n64 = 0;
    g1 = '0; g8 = '0; g32 = '0; g64 = '0;
    pulse_reseed(KEY_B, 1'b1);
    for (int c = 1; c <= 1500; c++) begin
      @(negedge clk);
      if (bus1.prng_out_valid  && f1  < 0) f1  = c;
      if (bus8.prng_out_valid  && f8  < 0) f8  = c;
      if (bus32.prng_out_valid && f32 < 0) f32 = c;
      if (bus64.prng_out_valid && f64 < 0) f64 = c;
      if (bus1.prng_out_valid  && n1  < 128) begin g1[n1 +: 1]   = bus1.prng_out_rnd;  n1  += 1;  end
      if (bus8.prng_out_valid  && n8  < 128) begin g8[n8 +: 8]   = bus8.prng_out_rnd;  n8  += 8;  end
      if (bus32.prng_out_valid && n32 < 128) begin g32[n32 +: 32] = bus32.prng_out_rnd; n32 += 32; end
      if (bus64.prng_out_valid && n64 < 128) begin g64[n64 +: 64] = bus64.prng_out_rnd; n64 += 64; end
      if (n1 >= 128 && n8 >= 128 && n32 >= 128 && n64 >= 128) break;
    end
    n_vec++; if (f1  != 1152) begin n_err++; $display("FAIL warm_u1 got=%0d exp=1152", f1); end
    n_vec++; if (f8  != 144)  begin n_err++; $display("FAIL warm_u8 got=%0d exp=144", f8); end
    n_vec++; if (f32 != 36)   begin n_err++; $display("FAIL warm_u32 got=%0d exp=36", f32); end
    n_vec++; if (f64 != 18)   begin n_err++; $display("FAIL warm_u64 got=%0d exp=18", f64); end
    n_vec++; if (g1[127:0]  !== ks_b[127:0]) begin n_err++; $display("FAIL ks_u1 got=%h exp=%h", g1[127:0], ks_b[127:0]); end
    n_vec++; if (g8[127:0]  !== ks_b[127:0]) begin n_err++; $display("FAIL ks_u8 got=%h exp=%h", g8[127:0], ks_b[127:0]); end
    n_vec++; if (g32[127:0] !== ks_b[127:0]) begin n_err++; $display("FAIL ks_u32 got=%h exp=%h", g32[127:0], ks_b[127:0]); end
    n_vec++; if (g64[127:0] !== ks_b[127:0]) begin n_err++; $display("FAIL ks_u64 got=%h exp=%h", g64[127:0], ks_b[127:0]); end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    nrst   = 1'b0;
    seed   = 80'h0;
    reseed = 1'b0;
    rdy64  = 1'b0;
    ks_zero = trivium_ref(80'h0, TB_IV);
    ks_b    = trivium_ref(KEY_B, TB_IV);
    test_reset();
    test_warmup_zero();
    test_ready_toggle();
    test_reseed_in_run();
    test_reseed_with_ready();
    test_reset_mid_warmup();
    test_unroll_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trivium_prng.md
# trivium_prng

Unrolled Trivium pseudo-random generator feeding fresh masking randomness to the masked AES-128 wrapper. It sits directly upstream of the AES core's randomness buses. It consumes the wrapper's 80-bit seed and reseed request, runs the mandatory 1152-step warm-up, and then streams UNROLL keystream bits per cycle under a valid/ready handshake.

## Interface
- UNROLL, 64: keystream bits produced per cycle; legal values are 1, 2, 4, 8, 16, 32 and 64.
- IV, 80'h0: fixed Trivium IV loaded on every reseed.
- clk  in  1  system clock; all state updates on the rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- prng_seed  in  80  Trivium key, sampled only on the edge where prng_start_reseed=1.
- prng_start_reseed  in  1  single-cycle reseed request, accepted in any state.
- prng_out_ready  in  1  consumer accepts the current word.
- prng_out_valid  out  UNROLL? no: 1  prng_out_rnd holds fresh, warmed-up keystream.
- prng_out_rnd  out  UNROLL  keystream word; bit i is keystream step i of the current state.
- prng_busy  out  1  high while in WARMUP.

## Operation
- State register: 288 bits, s1..s288.
  - Reseed load: s1..s80=prng_seed[0..79], s81..s93=0, s94..s173=IV[0..79], s174..s177=0, s178..s285=0, s286..s288=1.
- One Trivium step:
  - t1=s66^s93, t2=s162^s177, t3=s243^s288, z=t1^t2^t3.
  - t1^=(s91&s92)^s171, t2^=(s175&s176)^s264, t3^=(s286&s287)^s69.
  - Shift: s1..s93←t3,s1..s92; s94..s177←t1,s94..s176; s178..s288←t2,s178..s287.
- One cycle advance = UNROLL chained steps. z of step i drives prng_out_rnd[i].
- prng_out_rnd is a combinational function of the state register only. It is stable while prng_out_valid=1 and no advance occurs.
- FSM states:
  - IDLE (reset state): prng_out_valid=0. The state register is not advanced.
  - WARMUP: advance every cycle and increment the warm-up counter. When the counter reaches WARMUP_CYCLES-1 (WARMUP_CYCLES=1152/UNROLL), go to RUN.
  - RUN: prng_out_valid=1. Advance only on cycles with prng_out_valid & prng_out_ready.
- prng_start_reseed=1 in any state, including mid-WARMUP or RUN:
  - reload the state from the seed, clear the counter, go to WARMUP.
  - This has priority over advance and handshake in the same cycle. A word presented that cycle counts as not consumed.
- Warm-up counter: ceil(log2(WARMUP_CYCLES+1)) bits. It must not wrap, because it is cleared on entry to WARMUP.

## Timing
- Reset values (asynchronous): FSM=IDLE, state=0, counter=0, prng_out_valid=0, prng_busy=0, prng_out_rnd=0 (all-zero state gives z=0).
- Reseed sequence:
  - Edge E0 samples prng_start_reseed=1, loads the state and enters WARMUP; prng_busy=1 after E0.
  - Edges E1..E{WARMUP_CYCLES} advance the state.
  - After edge E{WARMUP_CYCLES}, FSM=RUN and prng_out_valid=1. For UNROLL=64 this is 18 cycles after E0.
- In RUN, each accepted handshake makes a new word visible after the same edge. Throughput is one word per cycle with prng_out_ready held high.
- prng_out_ready=0 holds the state; prng_out_rnd is unchanged.
- Reset asserted mid-operation returns everything to reset values immediately. A later reseed is required before prng_out_valid rises again.
- No combinational path from prng_out_ready to prng_out_valid.

## Structure
- Shared package holds:
  - register lengths 93/84/111 and STATE_W=288;
  - tap indices;
  - WARMUP_STEPS=1152;
  - the FSM state enum (IDLE, WARMUP, RUN).
- Sub-module trivium_step: combinational, 288-bit in/out plus z. The top level instantiates it UNROLL times in a generate chain.
- Top level holds only the state register, FSM, counter and handshake.

## Test plan
- Reset mid-WARMUP: assert nrst=0 at cycle 5 -> prng_out_valid=0 and prng_busy=0 immediately; prng_out_valid stays 0 with no reseed.
- Seed 80'h0, UNROLL=64, reseed pulse, prng_out_ready=1 -> prng_out_valid rises exactly 18 cycles after the sampling edge. The first 8 words match the golden Trivium model bit-for-bit, using key=0, IV=0 and bit i = keystream index i.
- Seed 80'h0123456789ABCDEF0123, ready toggled 1,0,0,1 -> word repeats while ready=0; the sequence equals the ready=1 sequence with no skips or duplicates.
- Reseed in RUN with the same seed -> prng_out_valid drops the next cycle and returns 18 cycles later; the first word equals the first word of the initial run.
- Reseed with ready=1 in the same cycle -> treated as reseed; the word is not consumed.
- Sweep UNROLL=1, 8, 32 -> warm-up takes 1152, 144 and 36 cycles respectively; the concatenated keystream is identical to UNROLL=64 for the same seed.
